// File: rtl/gcd_ctrl_pkg.sv
// Shared state encoding, operand-mux select codes and iteration-limit defaults for the GCD controller.
package gcd_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_B,
        CALC,
        DONE,
        ERROR
    } state_t;

    localparam logic SEL_A   = 1'b1;
    localparam logic SEL_B   = 1'b0;
    localparam logic SEL_SUB = 1'b1;
    localparam logic SEL_EXT = 1'b0;

    localparam int DEFAULT_MAX_ITER = 65536;
    localparam int DEFAULT_CNT_W    = 17;

endpackage

// File: rtl/gcd_iter_counter.sv
// Subtract-iteration counter: clears on entry to CALC and counts each subtract; at_max flags the abort point.
// Optional count output appears only when GCD_ITER_CNT_EN is defined.
module gcd_iter_counter #(
    parameter int MAX_ITER = 65536,
    parameter int CNT_W    = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
`ifdef GCD_ITER_CNT_EN
    output logic [CNT_W-1:0] count,
`endif
    output logic             at_max
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(MAX_ITER);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign at_max = (cnt_q == TERMINAL);

`ifdef GCD_ITER_CNT_EN
    assign count = cnt_q;
`endif

endmodule

// File: rtl/gcd_controller.sv
// Subtract-and-compare GCD sequencer: accepts A then B (valid/ready), N+1 cycles from B to done, done held until ack.
// Stalls input while busy; aborts with err on non-one-hot flags or MAX_ITER subtracts. GCD_ITER_CNT_EN adds iter_cnt.
module gcd_controller
    import gcd_ctrl_pkg::*;
#(
    parameter int MAX_ITER = DEFAULT_MAX_ITER,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic             ldA,
    output logic             ldB,
    output logic             sel1,
    output logic             sel2,
    output logic             sel_in,
    output logic             done,
    input  logic             done_ack,
    output logic             err,
    output logic             busy
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [CNT_W-1:0] iter_cnt
`endif
);

    state_t state, state_nxt;
    logic   cnt_clr, cnt_inc, at_max, one_hot;

    gcd_iter_counter #(
        .MAX_ITER (MAX_ITER),
        .CNT_W    (CNT_W)
    ) u_iter_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
`ifdef GCD_ITER_CNT_EN
        .count  (iter_cnt),
`endif
        .at_max (at_max)
    );

    assign one_hot = ({gt, lt, eq} == 3'b100) ||
                     ({gt, lt, eq} == 3'b010) ||
                     ({gt, lt, eq} == 3'b001);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ldA       = 1'b0;
        ldB       = 1'b0;
        sel1      = SEL_B;
        sel2      = SEL_B;
        sel_in    = SEL_EXT;
        done      = 1'b0;
        err       = 1'b0;
        busy      = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                ldA      = in_valid;
                if (in_valid) begin
                    state_nxt = WAIT_B;
                end
            end
            WAIT_B: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                ldB      = in_valid;
                if (in_valid) begin
                    state_nxt = CALC;
                    cnt_clr   = 1'b1;
                end
            end
            CALC: begin
                busy = 1'b1;
                // Corrupt flags abort first; a finished result beats the timeout.
                if (!one_hot) begin
                    state_nxt = ERROR;
                end else if (eq) begin
                    state_nxt = DONE;
                end else if (at_max) begin
                    state_nxt = ERROR;
                end else if (gt) begin
                    sel1    = SEL_A;
                    sel2    = SEL_B;
                    sel_in  = SEL_SUB;
                    ldA     = 1'b1;
                    cnt_inc = 1'b1;
                end else begin
                    sel1    = SEL_B;
                    sel2    = SEL_A;
                    sel_in  = SEL_SUB;
                    ldB     = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
                if (done_ack) begin
                    state_nxt = IDLE;
                end
            end
            ERROR: begin
                done = 1'b1;
                err  = 1'b1;
                busy = 1'b1;
                if (done_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench: two controllers (full MAX_ITER and a short one for timeouts) each closing the loop through a datapath,
// checked every cycle against an operand-level model plus literal expectations.
module tb_gcd_controller;

    localparam int MAX0 = 65536;
    localparam int MAX1 = 16;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, done_ack, corrupt;
    logic [15:0] data_in;
    logic [1:0]  in_ready, ld_a, ld_b, sel1, sel2, sel_in, done, err, busy, gt, lt, eq;
    logic [15:0] reg_a [2];
    logic [15:0] reg_b [2];
`ifdef GCD_ITER_CNT_EN
    logic [16:0] icnt0;
    logic [4:0]  icnt1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gcd_controller #(.MAX_ITER(MAX0), .CNT_W(17)) dut_big (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .gt(gt[0]), .lt(lt[0]), .eq(eq[0]), .ldA(ld_a[0]), .ldB(ld_b[0]),
        .sel1(sel1[0]), .sel2(sel2[0]), .sel_in(sel_in[0]), .done(done[0]),
        .done_ack(done_ack), .err(err[0]), .busy(busy[0])
`ifdef GCD_ITER_CNT_EN
        , .iter_cnt(icnt0)
`endif
    );

    gcd_controller #(.MAX_ITER(MAX1), .CNT_W(5)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .gt(gt[1]), .lt(lt[1]), .eq(eq[1]), .ldA(ld_a[1]), .ldB(ld_b[1]),
        .sel1(sel1[1]), .sel2(sel2[1]), .sel_in(sel_in[1]), .done(done[1]),
        .done_ack(done_ack), .err(err[1]), .busy(busy[1])
`ifdef GCD_ITER_CNT_EN
        , .iter_cnt(icnt1)
`endif
    );

    // Datapath: registers, operand muxes, subtractor, comparator (corrupt forces gt and lt together).
    function automatic logic [15:0] dp_sub(input int i);
        logic [15:0] m, s;
        m = sel1[i] ? reg_a[i] : reg_b[i];
        s = sel2[i] ? reg_a[i] : reg_b[i];
        return m - s;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ld_a[i]) reg_a[i] <= sel_in[i] ? dp_sub(i) : data_in;
            if (ld_b[i]) reg_b[i] <= sel_in[i] ? dp_sub(i) : data_in;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_flags
        assign gt[g] = corrupt | (reg_a[g] > reg_b[g]);
        assign lt[g] = corrupt | (reg_a[g] < reg_b[g]);
        assign eq[g] = !corrupt & (reg_a[g] == reg_b[g]);
    end

    // Operand-level model: phase 0 idle, 1 waiting for B, 2 computing, 3 finished.
    int          m_ph  [2];
    int          m_cnt [2];
    logic [15:0] m_a   [2];
    logic [15:0] m_b   [2];
    logic        m_err [2];
    logic        m_live = 1'b0;

    function automatic int max_of(input int i);
        return (i == 0) ? MAX0 : MAX1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_ph[i]  <= 0;
                m_cnt[i] <= 0;
                m_err[i] <= 1'b0;
                m_live   <= 1'b1;
            end else begin
                case (m_ph[i])
                    0: if (in_valid) begin m_a[i] <= data_in; m_ph[i] <= 1; end
                    1: if (in_valid) begin m_b[i] <= data_in; m_cnt[i] <= 0; m_ph[i] <= 2; end
                    2: begin
                        if (corrupt) begin
                            m_ph[i] <= 3; m_err[i] <= 1'b1;
                        end else if (m_a[i] == m_b[i]) begin
                            m_ph[i] <= 3; m_err[i] <= 1'b0;
                        end else if (m_cnt[i] == max_of(i)) begin
                            m_ph[i] <= 3; m_err[i] <= 1'b1;
                        end else if (m_a[i] > m_b[i]) begin
                            m_a[i] <= m_a[i] - m_b[i]; m_cnt[i] <= m_cnt[i] + 1;
                        end else begin
                            m_b[i] <= m_b[i] - m_a[i]; m_cnt[i] <= m_cnt[i] + 1;
                        end
                    end
                    default: if (done_ack) m_ph[i] <= 0;
                endcase
            end
        end
    end

    // {in_ready, ldA, ldB, sel1, sel2, sel_in, done, err, busy}
    function automatic logic [8:0] exp_vec(input int i);
        logic [8:0] v;
        v = '0;
        case (m_ph[i])
            0: begin v[8] = 1'b1; v[7] = in_valid; end
            1: begin v[8] = 1'b1; v[6] = in_valid; v[0] = 1'b1; end
            2: begin
                v[0] = 1'b1;
                if (!corrupt && m_a[i] != m_b[i] && m_cnt[i] != max_of(i)) begin
                    if (m_a[i] > m_b[i]) begin v[7] = 1'b1; v[5] = 1'b1; v[3] = 1'b1; end
                    else                 begin v[6] = 1'b1; v[4] = 1'b1; v[3] = 1'b1; end
                end
            end
            default: begin v[2] = 1'b1; v[1] = m_err[i]; v[0] = 1'b1; end
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("ctl[%0d]", i),
                    {23'd0, in_ready[i], ld_a[i], ld_b[i], sel1[i], sel2[i], sel_in[i], done[i], err[i], busy[i]},
                    {23'd0, exp_vec(i)});
                if (m_ph[i] == 3 && !m_err[i])
                    chk($sformatf("result[%0d]", i), {16'd0, reg_a[i]}, {16'd0, m_a[i]});
            end
`ifdef GCD_ITER_CNT_EN
            chk("iter_cnt[0]", {15'd0, icnt0}, m_cnt[0]);
            chk("iter_cnt[1]", {27'd0, icnt1}, m_cnt[1]);
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input int gap);
        in_valid = 1'b1; data_in = a;
        tick;
        in_valid = 1'b0;
        repeat (gap) tick;
        in_valid = 1'b1; data_in = b;
        tick;
        in_valid = 1'b0; data_in = '0;
    endtask

    task automatic wait_done(input int i, input int budget, output int cyc);
        cyc = 0;
        while (!done[i] && cyc < budget) begin
            tick;
            cyc++;
        end
    endtask

    task automatic ack_all;
        done_ack = 1'b1;
        tick;
        done_ack = 1'b0;
    endtask

    int c;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; done_ack = 1'b0; corrupt = 1'b0; data_in = '0;
        for (int i = 0; i < 2; i++) begin reg_a[i] = '0; reg_b[i] = '0; end
        repeat (2) tick;
        chk("reset_in_ready", {30'd0, in_ready}, 32'd3);
        chk("reset_outputs", {16'd0, ld_a, ld_b, sel1, sel2, sel_in, done, err, busy}, 32'd0);
        rst_n = 1'b1;
        tick;

        send_pair(16'd12, 16'd8, 0);
        wait_done(0, 10, c);
        chk("lat_12_8", c, 32'd3);
        chk("res_12_8", {16'd0, reg_a[0]}, 32'd4);
        chk("err_12_8", {30'd0, err}, 32'd0);
        chk("done_12_8_both", {30'd0, done}, 32'd3);
`ifdef GCD_ITER_CNT_EN
        chk("cnt_12_8", {15'd0, icnt0}, 32'd2);
`endif
        ack_all;

        send_pair(16'd9, 16'd9, 0);
        wait_done(0, 10, c);
        chk("lat_9_9", c, 32'd1);
        chk("res_9_9", {16'd0, reg_a[0]}, 32'd9);
        ack_all;

        send_pair(16'd0, 16'd0, 0);
        wait_done(0, 10, c);
        chk("lat_0_0", c, 32'd1);
        chk("res_0_0", {16'd0, reg_a[0]}, 32'd0);
        chk("err_0_0", {31'd0, err[0]}, 32'd0);
        ack_all;

        done_ack = 1'b1;
        tick;
        done_ack = 1'b0;
        chk("ack_in_idle", {30'd0, in_ready}, 32'd3);

        send_pair(16'd0, 16'd7, 0);
        wait_done(1, 40, c);
        chk("timeout_lat", c, 32'd17);
        chk("timeout_err", {31'd0, err[1]}, 32'd1);
        chk("big_still_busy", {30'd0, busy[0], done[0]}, 32'd2);
        ack_all;
        chk("timeout_ack_idle", {31'd0, in_ready[1]}, 32'd1);
        chk("big_ignores_ack", {30'd0, busy[0], in_ready[0]}, 32'd2);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;

        send_pair(16'd100, 16'd3, 0);
        repeat (5) tick;
        chk("midcalc_busy", {30'd0, busy}, 32'd3);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("midcalc_rst_ready", {30'd0, in_ready}, 32'd3);
        chk("midcalc_rst_outs", {16'd0, ld_a, ld_b, sel1, sel2, sel_in, done, err, busy}, 32'd0);
        send_pair(16'd21, 16'd14, 0);
        wait_done(0, 10, c);
        chk("lat_21_14", c, 32'd3);
        chk("res_21_14", {16'd0, reg_a[0]}, 32'd7);
        ack_all;

        send_pair(16'd18, 16'd12, 3);
        wait_done(0, 10, c);
        chk("lat_18_12", c, 32'd3);
        in_valid = 1'b1; data_in = 16'd99;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("hold_done", {30'd0, done}, 32'd3);
            chk("hold_no_ready", {30'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0; data_in = '0;
        ack_all;
        chk("stress_ready", {30'd0, in_ready}, 32'd3);
        chk("stress_res", {16'd0, reg_a[0]}, 32'd6);

        send_pair(16'd5, 16'd3, 0);
        corrupt = 1'b1;
        tick;
        corrupt = 1'b0;
        chk("flags_err", {28'd0, done, err}, 32'hF);
        ack_all;

        send_pair(16'd65535, 16'd1, 0);
        wait_done(0, 70000, c);
        chk("lat_65535_1", c, 32'd65535);
        chk("res_65535_1", {16'd0, reg_a[0]}, 32'd1);
        chk("err_65535_1", {30'd0, err}, 32'd2);
`ifdef GCD_ITER_CNT_EN
        chk("cnt_65535_1", {15'd0, icnt0}, 32'd65534);
`endif
        ack_all;
        chk("final_ready", {30'd0, in_ready}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
